// File: rtl/count_checker_pkg.sv
// Shared types and default sizing for the count sequence checker.
package count_checker_pkg;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_LOCK_RUN = 3;
    localparam int unsigned DEF_STAT_W   = 8;
    // Run length never exceeds the largest legal LOCK_RUN (15).
    localparam int unsigned RUN_W        = 4;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNCING  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating event counter; a clear coinciding with an event loads 1 so the event is kept.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/count_checker.sv
// Watches an up-counter bus, locks after LOCK_RUN consecutive in-sequence samples,
// and flags / counts sequence breaks and wraps while locked.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned LOCK_RUN = DEF_LOCK_RUN,
    parameter int unsigned STAT_W   = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    input  logic              clear_stats,
    output logic              locked,
    output logic              seq_error,
    output logic [WIDTH-1:0]  expected,
    output logic [STAT_W-1:0] error_count,
    output logic [STAT_W-1:0] wrap_count
);

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [WIDTH-1:0]   expected_q, expected_d;
    logic               seq_err_q, seq_err_d;
    logic               locked_q, locked_d;
    logic               err_inc;
    logic               wrap_inc;
    logic               match;

    assign match = (count_in == expected_q);

    // Next-state: every accepted sample reseeds the prediction from the observed value.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        expected_d = expected_q;
        seq_err_d  = 1'b0;
        err_inc    = 1'b0;
        wrap_inc   = 1'b0;
        if (count_valid) begin
            expected_d = count_in + WIDTH'(1);
            case (state_q)
                ST_UNLOCKED: begin
                    run_d   = RUN_W'(1);
                    state_d = ST_SYNCING;
                end
                ST_SYNCING: begin
                    if (match) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_d == RUN_W'(LOCK_RUN)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        run_d = RUN_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        wrap_inc = (count_in == '0);
                    end else begin
                        seq_err_d = 1'b1;
                        err_inc   = 1'b1;
                        run_d     = RUN_W'(1);
                        state_d   = ST_SYNCING;
                    end
                end
                default: begin
                    run_d   = '0;
                    state_d = ST_UNLOCKED;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_UNLOCKED;
            run_q      <= '0;
            expected_q <= '0;
            seq_err_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            expected_q <= expected_d;
            seq_err_q  <= seq_err_d;
            locked_q   <= locked_d;
        end
    end

    sat_counter #(.WIDTH(STAT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (err_inc),
        .clr   (clear_stats),
        .value (error_count)
    );

    sat_counter #(.WIDTH(STAT_W)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (wrap_inc),
        .clr   (clear_stats),
        .value (wrap_count)
    );

    assign locked    = locked_q;
    assign seq_error = seq_err_q;
    assign expected  = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: vector table plus reset and saturation sequences.
module tb_count_checker;

    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic       count_valid;
    logic       clear_stats;
    logic       locked;
    logic       seq_error;
    logic [3:0] expected;
    logic [7:0] error_count;
    logic [7:0] wrap_count;

    logic [3:0] count_in2;
    logic       count_valid2;
    logic       clear_stats2;
    logic       locked2;
    logic       seq_error2;
    logic [3:0] expected2;
    logic [7:0] error_count2;
    logic [7:0] wrap_count2;

    int n_total;
    int n_pass;

    count_checker dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .clear_stats (clear_stats),
        .locked      (locked),
        .seq_error   (seq_error),
        .expected    (expected),
        .error_count (error_count),
        .wrap_count  (wrap_count)
    );

    count_checker #(.WIDTH(4), .LOCK_RUN(2), .STAT_W(8)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in2),
        .count_valid (count_valid2),
        .clear_stats (clear_stats2),
        .locked      (locked2),
        .seq_error   (seq_error2),
        .expected    (expected2),
        .error_count (error_count2),
        .wrap_count  (wrap_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] cin;
        logic       clr;
        logic       lk;
        logic       se;
        logic [3:0] ex;
        logic [7:0] ec;
        logic [7:0] wc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] c, input logic clr);
        count_valid = v;
        count_in    = c;
        clear_stats = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic v, input logic [3:0] c, input logic clr);
        count_valid2 = v;
        count_in2    = c;
        clear_stats2 = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic lk, input logic se,
                             input logic [3:0] ex, input logic [7:0] ec, input logic [7:0] wc);
        check({tag, "_locked"},      32'(locked),      32'(lk));
        check({tag, "_seq_error"},   32'(seq_error),   32'(se));
        check({tag, "_expected"},    32'(expected),    32'(ex));
        check({tag, "_error_count"}, 32'(error_count), 32'(ec));
        check({tag, "_wrap_count"},  32'(wrap_count),  32'(wc));
    endtask

    initial begin
        logic [3:0] exp2;
        logic [3:0] bad;
        n_total = 0;
        n_pass  = 0;

        //                v  cin clr  lk se ex  ec wc
        vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd1,  8'd0, 8'd0});
        vecs.push_back('{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 4'd2,  8'd0, 8'd0});
        vecs.push_back('{1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 4'd3,  8'd0, 8'd0});
        vecs.push_back('{1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 4'd4,  8'd0, 8'd0});
        vecs.push_back('{1'b1, 4'd4,  1'b0, 1'b1, 1'b0, 4'd5,  8'd0, 8'd0});
        vecs.push_back('{1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 4'd10, 8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 4'd11, 8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 4'd12, 8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 4'd13, 8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd13, 1'b0, 1'b1, 1'b0, 4'd14, 8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 4'd15, 8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 4'd0,  8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 4'd1,  8'd1, 8'd1});
        vecs.push_back('{1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 4'd2,  8'd1, 8'd1});
        vecs.push_back('{1'b0, 4'd7,  1'b0, 1'b1, 1'b0, 4'd2,  8'd1, 8'd1});
        vecs.push_back('{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd2,  8'd1, 8'd1});
        vecs.push_back('{1'b0, 4'd3,  1'b0, 1'b1, 1'b0, 4'd2,  8'd1, 8'd1});
        vecs.push_back('{1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 4'd2,  8'd1, 8'd1});
        vecs.push_back('{1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 4'd3,  8'd1, 8'd1});
        vecs.push_back('{1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 4'd3,  8'd2, 8'd1});
        vecs.push_back('{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 4'd4,  8'd2, 8'd1});
        vecs.push_back('{1'b1, 4'd4,  1'b0, 1'b1, 1'b0, 4'd5,  8'd2, 8'd1});
        vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd5,  8'd0, 8'd0});
        vecs.push_back('{1'b1, 4'd9,  1'b1, 1'b0, 1'b1, 4'd10, 8'd1, 8'd0});
        vecs.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd10, 8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 4'd4,  8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 4'd5,  8'd1, 8'd0});
        vecs.push_back('{1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 4'd6,  8'd1, 8'd0});

        reset        = 1'b0;
        count_in     = '0;
        count_valid  = 1'b0;
        clear_stats  = 1'b0;
        count_in2    = '0;
        count_valid2 = 1'b0;
        clear_stats2 = 1'b0;

        #12;
        check_all("reset", 1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].cin, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].lk, vecs[i].se, vecs[i].ex,
                      vecs[i].ec, vecs[i].wc);
        end

        // Reset mid-lock, between clock edges: must clear without a clock edge.
        #3;
        reset = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
        step(1'b1, 4'd6, 1'b0);
        check_all("rst_held", 1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 4'd0, 1'b0);
        check_all("relock0", 1'b0, 1'b0, 4'd1, 8'd0, 8'd0);
        step(1'b1, 4'd1, 1'b0);
        check_all("relock1", 1'b0, 1'b0, 4'd2, 8'd0, 8'd0);
        step(1'b1, 4'd2, 1'b0);
        check_all("relock2", 1'b1, 1'b0, 4'd3, 8'd0, 8'd0);
        step(1'b0, 4'd0, 1'b0);

        // Saturation with LOCK_RUN=2: each error costs one bad and one good sample.
        step2(1'b1, 4'd0, 1'b0);
        check("sat_lock0", 32'(locked2), 32'(0));
        step2(1'b1, 4'd1, 1'b0);
        check("sat_lock1", 32'(locked2), 32'(1));
        exp2 = 4'd2;
        for (int i = 0; i < 260; i++) begin
            bad = exp2 + 4'd5;
            step2(1'b1, bad, 1'b0);
            exp2 = bad + 4'd1;
            step2(1'b1, exp2, 1'b0);
            exp2 = exp2 + 4'd1;
            if (i == 253) check("sat_254", 32'(error_count2), 32'(254));
            if (i == 254) check("sat_255", 32'(error_count2), 32'(255));
        end
        check("sat_final", 32'(error_count2), 32'(255));
        check("sat_locked", 32'(locked2), 32'(1));
        check("sat_expected", 32'(expected2), 32'(exp2));
        step2(1'b1, exp2 + 4'd3, 1'b1);
        check("clr_err_cnt", 32'(error_count2), 32'(1));
        check("clr_err_seq", 32'(seq_error2), 32'(1));
        step2(1'b0, 4'd0, 1'b0);
        check("clr_err_pulse", 32'(seq_error2), 32'(0));
        check("clr_err_hold", 32'(error_count2), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
